// File: rtl/prog_signal_gen.sv
// Programmable square/PWM source: period and high time in clock cycles, continuous or
// counted burst. New settings are staged and only take effect at a period boundary.
module prog_signal_gen #(
  parameter int CNT_W      = 24,
  parameter int BURST_W    = 16,
  parameter int DEF_PERIOD = 131072,
  parameter int DEF_HIGH   = 65536
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               load_i,
  input  logic [CNT_W-1:0]   period_i,
  input  logic [CNT_W-1:0]   high_i,
  input  logic [BURST_W-1:0] burst_i,
  output logic               signal_o,
  output logic               period_start_o,
  output logic               done_o,
  output logic               cfg_err_o,
  output logic               running_o
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0]   act_period_q, act_period_d, act_high_q, act_high_d;
  logic [BURST_W-1:0] act_burst_q, act_burst_d;
  logic [CNT_W-1:0]   pend_period_q, pend_period_d, pend_high_q, pend_high_d;
  logic [BURST_W-1:0] pend_burst_q, pend_burst_d;
  logic               pend_valid_q, pend_valid_d;
  logic               sig_q, sig_d, pstart_q, pstart_d, done_q, done_d, cfg_err_q, cfg_err_d;

  logic load_ok, go_run, advance, wrap, burst_end, take_pend;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      bcnt_q        <= '0;
      act_period_q  <= CNT_W'(DEF_PERIOD);
      act_high_q    <= CNT_W'(DEF_HIGH);
      act_burst_q   <= '0;
      pend_period_q <= CNT_W'(DEF_PERIOD);
      pend_high_q   <= CNT_W'(DEF_HIGH);
      pend_burst_q  <= '0;
      pend_valid_q  <= 1'b0;
      sig_q         <= 1'b0;
      pstart_q      <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      bcnt_q        <= bcnt_d;
      act_period_q  <= act_period_d;
      act_high_q    <= act_high_d;
      act_burst_q   <= act_burst_d;
      pend_period_q <= pend_period_d;
      pend_high_q   <= pend_high_d;
      pend_burst_q  <= pend_burst_d;
      pend_valid_q  <= pend_valid_d;
      sig_q         <= sig_d;
      pstart_q      <= pstart_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bcnt_d        = bcnt_q;
    act_period_d  = act_period_q;
    act_high_d    = act_high_q;
    act_burst_d   = act_burst_q;
    pend_period_d = pend_period_q;
    pend_high_d   = pend_high_q;
    pend_burst_d  = pend_burst_q;
    pend_valid_d  = pend_valid_q;
    go_run        = 1'b0;
    advance       = 1'b0;
    wrap          = 1'b0;
    burst_end     = 1'b0;
    take_pend     = 1'b0;
    load_ok       = (period_i >= CNT_W'(2)) && (high_i <= period_i);

    unique case (state_q)
      S_IDLE: begin
        // A finished burst leaves a non-zero burst config active, so a fresh Load re-arms.
        if (en_i && ((act_burst_q == '0) || pend_valid_q)) begin
          go_run    = 1'b1;
          state_d   = S_RUN;
          cnt_d     = '0;
          bcnt_d    = '0;
          take_pend = pend_valid_q;
        end
      end
      S_RUN: begin
        if (!en_i) begin
          state_d = S_IDLE;
        end else if (cnt_q < act_period_q - CNT_W'(1)) begin
          advance = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if ((act_burst_q != '0) &&
                     ((BURST_W+1)'(bcnt_q) + (BURST_W+1)'(1) == (BURST_W+1)'(act_burst_q))) begin
          burst_end = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wrap   = 1'b1;
          cnt_d  = '0;
          bcnt_d = (bcnt_q == '1) ? bcnt_q : bcnt_q + BURST_W'(1);
          if (pend_valid_q) begin
            take_pend = 1'b1;
            bcnt_d    = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_pend) begin
      act_period_d = pend_period_q;
      act_high_d   = pend_high_q;
      act_burst_d  = pend_burst_q;
      pend_valid_d = 1'b0;
    end
    // Applied after the consume so a same-edge Load stays pending for the next boundary.
    if (load_i && load_ok) begin
      pend_period_d = period_i;
      pend_high_d   = high_i;
      pend_burst_d  = burst_i;
      pend_valid_d  = 1'b1;
    end
  end

  always_comb begin
    sig_d     = 1'b0;
    pstart_d  = 1'b0;
    done_d    = burst_end;
    cfg_err_d = load_i && !load_ok;
    if (go_run || wrap) begin
      pstart_d = 1'b1;
      sig_d    = (act_high_d != '0);
    end else if (advance) begin
      sig_d = (cnt_d < act_high_q);
    end
  end

  assign signal_o       = sig_q;
  assign period_start_o = pstart_q;
  assign done_o         = done_q;
  assign cfg_err_o      = cfg_err_q;
  assign running_o      = (state_q == S_RUN);

endmodule
